// File: rtl/arp_tx_if.sv
// rtl/arp_tx_if.sv - request, CRC-side and GMII transmit signals of arp_tx
//
// Signal groups:
//   request  : tx_en, arp_tx_type, des_mac, des_ip   (requester -> arp_tx)
//   status   : tx_busy, tx_done                      (arp_tx -> requester)
//   crc side : crc32 (CRC block -> arp_tx), crc_en, crc_clr (arp_tx -> CRC block)
//   gmii     : gmii_tx_en, gmii_txd                  (arp_tx -> PHY)
// The slave modport is the arp_tx view; master is the surrounding system.
interface arp_tx_if;
    logic        tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic [31:0] crc32;
    logic        crc_en;
    logic        crc_clr;
    logic        tx_busy;
    logic        tx_done;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;

    modport master (
        output tx_en, arp_tx_type, des_mac, des_ip, crc32,
        input  crc_en, crc_clr, tx_busy, tx_done, gmii_tx_en, gmii_txd
    );

    modport slave (
        input  tx_en, arp_tx_type, des_mac, des_ip, crc32,
        output crc_en, crc_clr, tx_busy, tx_done, gmii_tx_en, gmii_txd
    );
endinterface

// File: rtl/arp_tx.sv
// rtl/arp_tx.sv - Ethernet II / ARP frame transmitter over 8-bit GMII
//
// Ports:
//   clk   : GMII TX clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : arp_tx_if.slave - request fields in, tx_busy/tx_done out,
//           crc32 in from the CRC block, crc_en/crc_clr out to it,
//           gmii_tx_en/gmii_txd out (the CRC block data input is gmii_txd)
// Frame: 7x55, D5, 14-byte header, 28-byte ARP body, 18 pad bytes, 4 FCS
// bytes, then IFG_BYTES idle cycles before the next request is sampled.
module arp_tx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A,
    parameter int          IFG_BYTES = 12
) (
    input  logic     clk,
    input  logic     rst_n,
    arp_tx_if.slave  bus
);
    localparam logic [6:0] IFG_LAST = 7'(IFG_BYTES - 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, FCS, IFG} state_t;

    state_t      state, next_state;
    logic [6:0]  cnt, cnt_next;
    logic        type_r;
    logic [47:0] mac_r;
    logic [31:0] ip_r;

    logic [7:0]  txd_d;
    logic        txen_d, crc_en_d, crc_clr_d, busy_d, done_d;

    // Byte i (0 = most significant) of a 48-bit field.
    function automatic logic [7:0] pick48(input logic [47:0] v, input logic [6:0] i);
        logic [47:0] s;
        s = v << {i, 3'b000};
        return s[47:40];
    endfunction

    // Byte i (0 = most significant) of a 32-bit field.
    function automatic logic [7:0] pick32(input logic [31:0] v, input logic [6:0] i);
        logic [31:0] s;
        s = v << {i, 3'b000};
        return s[31:24];
    endfunction

    // Outputs are registered, so they are decoded from the next state and
    // next count; this puts the first 0x55 on the wire the cycle after the
    // request is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            type_r         <= 1'b0;
            mac_r          <= '0;
            ip_r           <= '0;
            bus.gmii_tx_en <= 1'b0;
            bus.gmii_txd   <= '0;
            bus.crc_en     <= 1'b0;
            bus.crc_clr    <= 1'b0;
            bus.tx_busy    <= 1'b0;
            bus.tx_done    <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (state == IDLE && bus.tx_en) begin
                type_r <= bus.arp_tx_type;
                mac_r  <= bus.des_mac;
                ip_r   <= bus.des_ip;
            end
            bus.gmii_tx_en <= txen_d;
            bus.gmii_txd   <= txd_d;
            bus.crc_en     <= crc_en_d;
            bus.crc_clr    <= crc_clr_d;
            bus.tx_busy    <= busy_d;
            bus.tx_done    <= done_d;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt + 7'd1;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (bus.tx_en) next_state = PREAMBLE;
            end
            PREAMBLE: if (cnt == 7'd7)     begin next_state = ETH_HEAD; cnt_next = '0; end
            ETH_HEAD: if (cnt == 7'd13)    begin next_state = ARP_DATA; cnt_next = '0; end
            ARP_DATA: if (cnt == 7'd45)    begin next_state = FCS;      cnt_next = '0; end
            FCS:      if (cnt == 7'd3)     begin next_state = IFG;      cnt_next = '0; end
            IFG:      if (cnt == IFG_LAST) begin next_state = IDLE;     cnt_next = '0; end
            default:                       begin next_state = IDLE;     cnt_next = '0; end
        endcase
    end

    always_comb begin
        txd_d     = '0;
        txen_d    = 1'b0;
        crc_en_d  = 1'b0;
        crc_clr_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (next_state)
            PREAMBLE: begin
                txen_d = 1'b1;
                busy_d = 1'b1;
                txd_d  = (cnt_next == 7'd7) ? 8'hD5 : 8'h55;
            end
            ETH_HEAD: begin
                txen_d   = 1'b1;
                busy_d   = 1'b1;
                crc_en_d = 1'b1;
                if (cnt_next < 7'd6)       txd_d = type_r ? pick48(mac_r, cnt_next) : 8'hFF;
                else if (cnt_next < 7'd12) txd_d = pick48(BOARD_MAC, cnt_next - 7'd6);
                else if (cnt_next == 7'd12) txd_d = 8'h08;
                else                        txd_d = 8'h06;
            end
            ARP_DATA: begin
                txen_d   = 1'b1;
                busy_d   = 1'b1;
                crc_en_d = 1'b1;
                if (cnt_next < 7'd8) begin
                    case (cnt_next[2:0])
                        3'd1:    txd_d = 8'h01;
                        3'd2:    txd_d = 8'h08;
                        3'd4:    txd_d = 8'h06;
                        3'd5:    txd_d = 8'h04;
                        3'd7:    txd_d = type_r ? 8'h02 : 8'h01;
                        default: txd_d = 8'h00;
                    endcase
                end
                else if (cnt_next < 7'd14) txd_d = pick48(BOARD_MAC, cnt_next - 7'd8);
                else if (cnt_next < 7'd18) txd_d = pick32(BOARD_IP, cnt_next - 7'd14);
                else if (cnt_next < 7'd24) txd_d = type_r ? pick48(mac_r, cnt_next - 7'd18) : 8'h00;
                else if (cnt_next < 7'd28) txd_d = pick32(ip_r, cnt_next - 7'd24);
                else                       txd_d = 8'h00;
            end
            FCS: begin
                txen_d = 1'b1;
                busy_d = 1'b1;
                // FCS goes out least significant byte first.
                txd_d  = pick32(bus.crc32, 7'd3 - cnt_next);
            end
            IFG: begin
                busy_d = 1'b1;
                if (cnt_next == 7'd0) begin
                    done_d    = 1'b1;
                    crc_clr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_arp_tx.sv
// tb/tb_arp_tx.sv - randomized self-checking bench for arp_tx
module tb_arp_tx;
    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arp_tx_if bus();

    arp_tx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP), .IFG_BYTES(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Stand-in for the downstream CRC block: updates on the falling edge.
    logic [31:0] crc_st;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n)           crc_st <= 32'hFFFFFFFF;
        else if (bus.crc_clr) crc_st <= 32'hFFFFFFFF;
        else if (bus.crc_en)  crc_st <= crc_byte(crc_st, bus.gmii_txd);
    end
    assign bus.crc32 = ~crc_st;

    typedef struct {
        bit          typ;
        logic [47:0] mac;
        logic [31:0] ip;
    } req_t;

    req_t exp_q[$];

    // Reference frame assembled field by field.
    function automatic void build(input req_t r, output logic [7:0] f[72]);
        logic [7:0]  q[$];
        logic [31:0] c;
        q = {};
        repeat (7) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) q.push_back(r.typ ? r.mac[47-8*i -: 8] : 8'hFF);
        for (int i = 0; i < 6; i++) q.push_back(BOARD_MAC[47-8*i -: 8]);
        q.push_back(8'h08); q.push_back(8'h06);
        q.push_back(8'h00); q.push_back(8'h01); q.push_back(8'h08); q.push_back(8'h00);
        q.push_back(8'h06); q.push_back(8'h04); q.push_back(8'h00);
        q.push_back(r.typ ? 8'h02 : 8'h01);
        for (int i = 0; i < 6; i++) q.push_back(BOARD_MAC[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) q.push_back(BOARD_IP[31-8*i -: 8]);
        for (int i = 0; i < 6; i++) q.push_back(r.typ ? r.mac[47-8*i -: 8] : 8'h00);
        for (int i = 0; i < 4; i++) q.push_back(r.ip[31-8*i -: 8]);
        repeat (18) q.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 68; i++) c = crc_byte(c, q[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
        for (int i = 0; i < 72; i++) f[i] = q[i];
    endfunction

    // Monitor
    int          cyc = 0;
    logic [7:0]  cap[$];
    logic [71:0] en_mask;
    bit          in_frame = 0;
    int          start_cyc = 0;
    int          starts[$];
    int          nframes = 0;
    int          nbytes = 0;
    int          busy_start = 0;
    bit          busy_prev = 0;

    task automatic finish_frame();
        logic [7:0]  f[72];
        logic [71:0] m;
        req_t        r;
        nframes++;
        check("frame_len", 72'(cap.size()), 72'd72);
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 72'd1, 72'd0);
        end else begin
            r = exp_q.pop_front();
            build(r, f);
            for (int i = 0; i < 72 && i < cap.size(); i++)
                check($sformatf("byte%0d", i), 72'(cap[i]), 72'(f[i]));
            m = '0;
            for (int i = 8; i < 68; i++) m[i] = 1'b1;
            check("crc_en_window", en_mask, m);
        end
        nbytes = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            if (in_frame) void'(exp_q.pop_front());
            in_frame  = 0;
            busy_prev = 0;
            nbytes    = 0;
        end else begin
            if (bus.gmii_tx_en) begin
                if (!in_frame) begin
                    in_frame  = 1;
                    cap       = {};
                    en_mask   = '0;
                    start_cyc = cyc;
                    starts.push_back(cyc);
                end
                if (cap.size() < 72) en_mask[cap.size()] = bus.crc_en;
                cap.push_back(bus.gmii_txd);
                nbytes = cap.size();
            end else begin
                if (in_frame) begin
                    in_frame = 0;
                    finish_frame();
                end
                if (bus.crc_en) check("crc_en_outside_frame", 72'd1, 72'd0);
                if (bus.gmii_txd != 8'h00) check("txd_idle", 72'(bus.gmii_txd), 72'd0);
            end
            if (bus.tx_done) check("done_latency", 72'(cyc - start_cyc), 72'd72);
            if (bus.crc_clr != bus.tx_done) check("crc_clr_vs_done", 72'(bus.crc_clr), 72'(bus.tx_done));
            if (bus.tx_busy && !busy_prev) busy_start = cyc;
            if (!bus.tx_busy && busy_prev) check("busy_len", 72'(cyc - busy_start), 72'd84);
            busy_prev = bus.tx_busy;
        end
    end

    // Stimulus
    task automatic scramble();
        bus.arp_tx_type = 1'($urandom);
        bus.des_mac     = {16'($urandom), $urandom};
        bus.des_ip      = $urandom;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400; i++) begin
            if (!bus.tx_busy && !bus.gmii_tx_en) break;
            @(posedge clk);
        end
        if (i == 400) check("idle_timeout", 72'd0, 72'd1);
    endtask

    task automatic wait_frames(input int n);
        int i;
        for (i = 0; i < 400; i++) begin
            if (nframes >= n) break;
            @(posedge clk);
        end
        if (i == 400) check("frame_timeout", 72'(nframes), 72'(n));
    endtask

    task automatic wait_bytes(input int n);
        int i;
        for (i = 0; i < 200; i++) begin
            if (nbytes >= n) break;
            @(posedge clk);
        end
        if (i == 200) check("byte_timeout", 72'(nbytes), 72'(n));
    endtask

    task automatic send(input bit typ, input logic [47:0] mac, input logic [31:0] ip);
        req_t r;
        wait_idle();
        @(posedge clk); #1;
        bus.tx_en = 1'b1; bus.arp_tx_type = typ; bus.des_mac = mac; bus.des_ip = ip;
        r.typ = typ; r.mac = mac; r.ip = ip;
        exp_q.push_back(r);
        @(posedge clk); #1;
        bus.tx_en = 1'b0;
        scramble();   // must not disturb the frame already latched
    endtask

    function automatic logic [71:0] outs();
        return 72'({bus.gmii_tx_en, bus.gmii_txd, bus.crc_en, bus.crc_clr, bus.tx_busy, bus.tx_done});
    endfunction

    initial begin
        int nf;
        int base;
        int i;
        req_t r;

        bus.tx_en = 1'b0; bus.arp_tx_type = 1'b0; bus.des_mac = '0; bus.des_ip = '0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", outs(), 72'd0);
        #2 rst_n = 1'b1;

        send(1'b0, {16'($urandom), $urandom}, 32'hC0A80102);
        wait_frames(1);
        send(1'b1, 48'hAA_BB_CC_DD_EE_FF, $urandom);
        wait_frames(2);
        for (int k = 0; k < 4; k++) begin
            send(1'($urandom), {16'($urandom), $urandom}, $urandom);
            wait_frames(3 + k);
        end

        // Busy rejection: a second request mid-frame is dropped.
        send(1'b0, {16'($urandom), $urandom}, $urandom);
        nf = nframes;
        wait_bytes(30);
        @(posedge clk); #1;
        bus.tx_en = 1'b1; bus.des_ip = bus.des_ip ^ 32'h0000_00FF;
        @(posedge clk); #1;
        bus.tx_en = 1'b0;
        wait_frames(nf + 1);
        wait_idle();
        repeat (30) @(posedge clk);
        check("no_second_frame", 72'(nframes), 72'(nf + 1));

        // Back-to-back with tx_en held high for three frames.
        wait_idle();
        base = starts.size();
        nf = nframes;
        @(posedge clk); #1;
        r.typ = 1'($urandom); r.mac = {16'($urandom), $urandom}; r.ip = $urandom;
        bus.tx_en = 1'b1; bus.arp_tx_type = r.typ; bus.des_mac = r.mac; bus.des_ip = r.ip;
        repeat (3) exp_q.push_back(r);
        for (i = 0; i < 400; i++) begin
            if (starts.size() >= base + 3) break;
            @(posedge clk);
        end
        if (i == 400) check("b2b_start_timeout", 72'(starts.size()), 72'(base + 3));
        #1 bus.tx_en = 1'b0;
        wait_frames(nf + 3);
        if (starts.size() >= base + 3) begin
            check("b2b_gap1", 72'(starts[base+1] - starts[base]), 72'd85);
            check("b2b_gap2", 72'(starts[base+2] - starts[base+1]), 72'd85);
        end
        wait_idle();
        repeat (20) @(posedge clk);
        check("b2b_count", 72'(nframes), 72'(nf + 3));

        // Reset mid-frame at byte 20.
        send(1'b1, {16'($urandom), $urandom}, $urandom);
        nf = nframes;
        wait_bytes(20);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check("mid_reset_outputs", outs(), 72'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check("aborted_not_counted", 72'(nframes), 72'(nf));
        send(1'b0, {16'($urandom), $urandom}, $urandom);
        wait_frames(nf + 1);
        wait_idle();
        repeat (5) @(posedge clk);
        check("expected_queue_empty", 72'(exp_q.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
